// File: rtl/div_pipe_32by16_pkg.sv
// Shared types and sizing helpers for the 32/16 iterative restoring divider.
package div_pkg;

    localparam int DIV_DW_A = 32;
    localparam int DIV_DW_B = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_e;

    // Counter width needed to count n iterations (0..n-1).
    function automatic int div_cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/div_pipe_32by16_if.sv
// Request/result bundle for div_pipe_32by16; div_zero only exists with DIV_ZERO_CHK_EN.
interface div_pipe_32by16_if
    import div_pkg::*;
#(
    parameter int DW_A = DIV_DW_A,
    parameter int DW_B = DIV_DW_B
);
    logic [DW_A-1:0] div_a;
    logic [DW_B-1:0] div_b;
    logic            div_en_in;
    logic            div_busy;
    logic            div_en_out;
    logic [DW_A-1:0] div_out;
    logic [DW_B-1:0] div_rem;
`ifdef DIV_ZERO_CHK_EN
    logic            div_zero;
`endif

    modport master (
        output div_a, div_b, div_en_in,
        input  div_busy, div_en_out, div_out, div_rem
`ifdef DIV_ZERO_CHK_EN
        , input div_zero
`endif
    );

    modport slave (
        input  div_a, div_b, div_en_in,
        output div_busy, div_en_out, div_out, div_rem
`ifdef DIV_ZERO_CHK_EN
        , output div_zero
`endif
    );
endinterface

// File: rtl/div_pipe_32by16_step.sv
// One combinational restoring step: shift in a dividend bit, subtract divisor if it fits.
module div_step #(
    parameter int DW_B = 16
) (
    input  logic [DW_B:0]   i_r,
    input  logic            i_bit,
    input  logic [DW_B-1:0] i_d,
    output logic [DW_B:0]   o_r,
    output logic            o_q
);
    logic [DW_B:0] w_sh;
    logic [DW_B:0] w_d;

    // Remainder entering a step is below the divisor, so its top bit is always
    // clear and dropping it in the shift loses nothing (except for divisor 0,
    // where the low dividend bits are exactly what should remain).
    assign w_sh = {i_r[DW_B-1:0], i_bit};
    assign w_d  = {1'b0, i_d};
    assign o_q  = (w_sh >= w_d);
    assign o_r  = o_q ? (w_sh - w_d) : w_sh;
endmodule

// File: rtl/div_pipe_32by16.sv
// Iterative restoring divider, BITS_PER_CYC quotient bits per clock.
// Optional DIV_ZERO_CHK_EN: short-cuts zero divisors and raises div_zero.
module div_pipe_32by16
    import div_pkg::*;
#(
    parameter int DW_A         = DIV_DW_A,
    parameter int DW_B         = DIV_DW_B,
    parameter int BITS_PER_CYC = 1
) (
    input  logic               clk,
    input  logic               rst,
    div_pipe_32by16_if.slave   dif
);
    localparam int N  = DW_A / BITS_PER_CYC;
    localparam int CW = div_cnt_w(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_CALC = CALC;
    localparam logic [1:0] ST_DONE = DONE;

    logic [1:0]      r_state;
    logic [CW-1:0]   r_cnt;
    logic [DW_A-1:0] r_a;
    logic [DW_B-1:0] r_d;
    logic [DW_B:0]   r_r;
    logic            r_en_out;
    logic [DW_A-1:0] r_out;
    logic [DW_B-1:0] r_rem;
`ifdef DIV_ZERO_CHK_EN
    logic            r_zero;
`endif

    logic [DW_B:0]           w_r [BITS_PER_CYC+1];
    logic [BITS_PER_CYC-1:0] w_qv;
    logic [DW_A-1:0]         w_a_nxt;

    assign w_r[0] = r_r;

    for (genvar k = 0; k < BITS_PER_CYC; k++) begin : g_step
        div_step #(.DW_B(DW_B)) u_step (
            .i_r   (w_r[k]),
            .i_bit (r_a[DW_A-1-k]),
            .i_d   (r_d),
            .o_r   (w_r[k+1]),
            .o_q   (w_qv[BITS_PER_CYC-1-k])
        );
    end

    // Dividend bits leave at the top while quotient bits enter at the bottom,
    // so after N cycles r_a holds the full quotient.
    assign w_a_nxt = {r_a[DW_A-BITS_PER_CYC-1:0], w_qv};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_a      <= '0;
            r_d      <= '0;
            r_r      <= '0;
            r_en_out <= 1'b0;
            r_out    <= '0;
            r_rem    <= '0;
`ifdef DIV_ZERO_CHK_EN
            r_zero   <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_en_out <= 1'b0;
                    if (dif.div_en_in) begin
                        r_a     <= dif.div_a;
                        r_d     <= dif.div_b;
                        r_r     <= '0;
                        r_cnt   <= '0;
                        r_state <= ST_CALC;
                    end
                end
                ST_CALC: begin
`ifdef DIV_ZERO_CHK_EN
                    if (r_d == '0) begin
                        r_out    <= '1;
                        r_rem    <= r_a[DW_B-1:0];
                        r_zero   <= 1'b1;
                        r_en_out <= 1'b1;
                        r_state  <= ST_DONE;
                    end else
`endif
                    begin
                        r_a   <= w_a_nxt;
                        r_r   <= w_r[BITS_PER_CYC];
                        r_cnt <= r_cnt + CW'(1);
                        if (r_cnt == LAST) begin
                            r_out    <= w_a_nxt;
                            r_rem    <= w_r[BITS_PER_CYC][DW_B-1:0];
`ifdef DIV_ZERO_CHK_EN
                            r_zero   <= 1'b0;
`endif
                            r_en_out <= 1'b1;
                            r_state  <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    r_en_out <= 1'b0;
                    r_state  <= ST_IDLE;
                end
                default: begin
                    r_en_out <= 1'b0;
                    r_state  <= ST_IDLE;
                end
            endcase
        end
    end

    assign dif.div_busy   = (r_state != ST_IDLE);
    assign dif.div_en_out = r_en_out;
    assign dif.div_out    = r_out;
    assign dif.div_rem    = r_rem;
`ifdef DIV_ZERO_CHK_EN
    assign dif.div_zero   = r_zero;
`endif
endmodule

// File: tb/tb_div_pipe_32by16.sv
// Scoreboard bench for div_pipe_32by16: directed vectors, reset abort, random invariant sweep.
module tb_div_pipe_32by16;
    localparam int N = 32;

    typedef struct {
        logic [31:0] a;
        logic [15:0] b;
        logic [31:0] q;
        logic [15:0] r;
        logic        z;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk  = 0;
    int   n_fail = 0;
    exp_t sb[$];

    div_pipe_32by16_if dif ();

    div_pipe_32by16 dut (
        .clk (clk),
        .rst (rst),
        .dif (dif)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: pops one expectation per result pulse.
    always @(negedge clk) begin
        if (!rst && dif.div_en_out) begin
            if (sb.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_result: got q=%0h r=%0h expected no pulse",
                         dif.div_out, dif.div_rem);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("quotient", 64'(dif.div_out), 64'(e.q));
                chk("remainder", 64'(dif.div_rem), 64'(e.r));
`ifdef DIV_ZERO_CHK_EN
                chk("div_zero", 64'(dif.div_zero), 64'(e.z));
`endif
                if (e.b != 0) begin
                    chk("invariant", 64'(dif.div_out) * 64'(e.b) + 64'(dif.div_rem), 64'(e.a));
                    chk("rem_lt_div", 64'(dif.div_rem < e.b), 64'd1);
                end
            end
        end
    end

    task automatic run(input logic [31:0] a, input logic [15:0] b,
                       input logic [31:0] q, input logic [15:0] r, input bit inj);
        int   lat;
        int   cyc;
        exp_t e;
        lat = N;
`ifdef DIV_ZERO_CHK_EN
        if (b == 0) lat = 1;
`endif
        e.a = a; e.b = b; e.q = q; e.r = r; e.z = (b == 0);
        sb.push_back(e);
        @(negedge clk);
        dif.div_a     = a;
        dif.div_b     = b;
        dif.div_en_in = 1'b1;
        @(posedge clk);
        #1 dif.div_en_in = 1'b0;
        chk("busy_after_accept", 64'(dif.div_busy), 64'd1);
        cyc = 0;
        while (cyc < 60) begin
            @(posedge clk);
            cyc++;
            #1;
            if (inj && cyc == 4) begin
                dif.div_a     = 32'hDEAD_BEEF;
                dif.div_b     = 16'h0003;
                dif.div_en_in = 1'b1;
            end
            if (inj && cyc == 5) dif.div_en_in = 1'b0;
            if (dif.div_en_out) break;
        end
        chk("latency", 64'(cyc), 64'(lat));
        chk("busy_at_done", 64'(dif.div_busy), 64'd1);
        @(posedge clk);
        #1;
        chk("pulse_width", 64'(dif.div_en_out), 64'd0);
        chk("busy_idle", 64'(dif.div_busy), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] ra;
        logic [15:0] rb;
        int          seen;
        dif.div_a     = '0;
        dif.div_b     = '0;
        dif.div_en_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 64'(dif.div_busy), 64'd0);
        chk("rst_en_out", 64'(dif.div_en_out), 64'd0);
        chk("rst_out", 64'(dif.div_out), 64'd0);
        chk("rst_rem", 64'(dif.div_rem), 64'd0);
`ifdef DIV_ZERO_CHK_EN
        chk("rst_zero", 64'(dif.div_zero), 64'd0);
`endif
        @(negedge clk);
        rst = 1'b0;

        run(32'd200000000, 16'd20000, 32'd10000, 16'd0, 1'b0);
        run(32'd100, 16'd7, 32'd14, 16'd2, 1'b0);
        run(32'hFFFF_FFFF, 16'd1, 32'hFFFF_FFFF, 16'd0, 1'b0);
        run(32'd5, 16'd9, 32'd0, 16'd5, 1'b0);
        run(32'h0001_2345, 16'd0, 32'hFFFF_FFFF, 16'h2345, 1'b0);
        // Second strobe mid-flight must be ignored; the follow-up is accepted at T0+34.
        run(32'd1000, 16'd10, 32'd100, 16'd0, 1'b1);
        run(32'd65535, 16'd256, 32'd255, 16'd255, 1'b0);

        // Reset mid-operation: outputs clear at once and no result follows.
        @(negedge clk);
        dif.div_a     = 32'd1000;
        dif.div_b     = 16'd3;
        dif.div_en_in = 1'b1;
        @(posedge clk);
        #1 dif.div_en_in = 1'b0;
        repeat (9) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("abort_out", 64'(dif.div_out), 64'd0);
        chk("abort_rem", 64'(dif.div_rem), 64'd0);
        chk("abort_busy", 64'(dif.div_busy), 64'd0);
        chk("abort_en_out", 64'(dif.div_en_out), 64'd0);
        @(negedge clk);
        rst  = 1'b0;
        seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (dif.div_en_out) seen++;
        end
        chk("no_pulse_after_abort", 64'(seen), 64'd0);

        for (int i = 0; i < 1000; i++) begin
            ra = $urandom;
            rb = (i % 2 == 0) ? 16'($urandom_range(1, 65535)) : 16'($urandom_range(1, 255));
            run(ra, rb, ra / 32'(rb), 16'(ra % 32'(rb)), 1'b0);
        end

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
